// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared constants and types for the register file write-port arbiter:
// reset polarity, write-enable encodings, register file geometry and FSM states.
package regfile_wport_arbiter_pkg;

    localparam logic RST_ACTIVE = 1'b1;

    localparam logic WE_ON  = 1'b1;
    localparam logic WE_OFF = 1'b0;

    localparam int REG_NUM      = 32;
    localparam int REG_NUM_LOG2 = $clog2(REG_NUM);
    localparam int REG_W        = 32;

    localparam logic [REG_W-1:0] ZERO_WORD = '0;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_wport_arbiter_if.sv
// Bundle of the write-port request sources, the register file write bus and the
// pipeline-facing status lines. slave is the arbiter side, master the surroundings.
interface regfile_wport_arbiter_if
    import regfile_wport_arbiter_pkg::*;
#(
    parameter int REG_ADDR_W = REG_NUM_LOG2,
    parameter int DATA_W     = REG_W
);

    logic                  wb_we;
    logic [REG_ADDR_W-1:0] wb_waddr;
    logic [DATA_W-1:0]     wb_wdata;

    logic                  aux_req;
    logic [REG_ADDR_W-1:0] aux_waddr;
    logic [DATA_W-1:0]     aux_wdata;
    logic                  aux_ack;

    logic                  reg_we;
    logic [REG_ADDR_W-1:0] reg_waddr;
    logic [DATA_W-1:0]     reg_wdata;

    logic                  stall_req;
    logic                  init_busy;

    modport master (
        output wb_we, wb_waddr, wb_wdata,
        output aux_req, aux_waddr, aux_wdata,
        input  aux_ack,
        input  reg_we, reg_waddr, reg_wdata,
        input  stall_req, init_busy
    );

    modport slave (
        input  wb_we, wb_waddr, wb_wdata,
        input  aux_req, aux_waddr, aux_wdata,
        output aux_ack,
        output reg_we, reg_waddr, reg_wdata,
        output stall_req, init_busy
    );

endinterface

// File: rtl/regfile_wport_arbiter_starve_ctr.sv
// Saturating count of consecutive un-acked aux request cycles; raises a sticky
// stall flag once the limit is hit, released only by the aux grant.
module wport_starve_ctr #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic aux_req,
    input  logic aux_ack,
    output logic starve_stall
);
    import regfile_wport_arbiter_pkg::*;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] cnt_next;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == LIMIT) ? LIMIT : v + 1'b1;
    endfunction

    assign cnt_next = sat_inc(starve_cnt);

    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            starve_cnt   <= '0;
            starve_stall <= 1'b0;
        end else if (run) begin
            if (aux_ack) begin
                starve_cnt   <= '0;
                starve_stall <= 1'b0;
            end else if (!aux_req) begin
                starve_cnt <= '0;
            end else begin
                starve_cnt <= cnt_next;
                // Flag rises on the same edge the count reaches the limit.
                if (cnt_next == LIMIT) begin
                    starve_stall <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Owner of the register file write port: clears r1..r(N-1) after reset, then
// arbitrates between fixed-priority writeback and the req/ack auxiliary source.
module regfile_wport_arbiter #(
    parameter int REG_NUM      = regfile_wport_arbiter_pkg::REG_NUM,
    parameter int REG_ADDR_W   = regfile_wport_arbiter_pkg::REG_NUM_LOG2,
    parameter int DATA_W       = regfile_wport_arbiter_pkg::REG_W,
    parameter int STARVE_LIMIT = 4
) (
    input logic                    clk,
    input logic                    rst,
    regfile_wport_arbiter_if.slave bus
);
    import regfile_wport_arbiter_pkg::*;

    localparam logic [REG_ADDR_W-1:0] FIRST_REG = REG_ADDR_W'(1);
    localparam logic [REG_ADDR_W-1:0] LAST_REG  = REG_ADDR_W'(REG_NUM - 1);
    localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = '0;

    state_t                state;
    logic [REG_ADDR_W-1:0] clr_ptr;
    logic                  starve_stall;
    logic                  in_run;
    logic                  wb_valid;

    logic                  we;
    logic [REG_ADDR_W-1:0] waddr;
    logic [DATA_W-1:0]     wdata;
    logic                  ack;
    logic                  stall;
    logic                  busy;

    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            state   <= CLEAR;
            clr_ptr <= FIRST_REG;
        end else begin
            case (state)
                CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == LAST_REG) begin
                        state <= RUN;
                    end
                end
                RUN:     state <= RUN;
                default: state <= CLEAR;
            endcase
        end
    end

    assign in_run   = (rst != RST_ACTIVE) && (state == RUN);
    assign wb_valid = bus.wb_we && (bus.wb_waddr != ZERO_ADDR);

    // Outputs are combinational so a writeback lands in the regfile this cycle.
    always_comb begin
        we    = WE_OFF;
        waddr = '0;
        wdata = '0;
        ack   = 1'b0;
        stall = 1'b1;
        busy  = 1'b1;
        if (rst != RST_ACTIVE) begin
            case (state)
                CLEAR: begin
                    we    = WE_ON;
                    waddr = clr_ptr;
                end
                RUN: begin
                    busy  = 1'b0;
                    stall = starve_stall;
                    if (wb_valid) begin
                        we    = WE_ON;
                        waddr = bus.wb_waddr;
                        wdata = bus.wb_wdata;
                    end else if (bus.aux_req) begin
                        // r0 writes are still acked but never reach the array.
                        ack   = 1'b1;
                        we    = (bus.aux_waddr != ZERO_ADDR) ? WE_ON : WE_OFF;
                        waddr = bus.aux_waddr;
                        wdata = bus.aux_wdata;
                    end
                end
                default: begin
                    we = WE_OFF;
                end
            endcase
        end
    end

    wport_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk          (clk),
        .rst          (rst),
        .run          (in_run),
        .aux_req      (bus.aux_req),
        .aux_ack      (ack),
        .starve_stall (starve_stall)
    );

    assign bus.reg_we    = we;
    assign bus.reg_waddr = waddr;
    assign bus.reg_wdata = wdata;
    assign bus.aux_ack   = ack;
    assign bus.stall_req = stall;
    assign bus.init_busy = busy;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Bench for regfile_wport_arbiter: directed scenarios plus a randomized run
// against a cycle-level behavioural model, with a bench-owned register file.
module tb_regfile_wport_arbiter;
    import regfile_wport_arbiter_pkg::*;

    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst;
    logic scramble;
    int   n_cmp;
    int   n_err;

    logic [31:0] mem [32];
    logic [40:0] got;
    logic [40:0] exp_v;

    always #5 clk = ~clk;

    regfile_wport_arbiter_if bus ();

    regfile_wport_arbiter #(
        .REG_NUM      (32),
        .REG_ADDR_W   (5),
        .DATA_W       (32),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Bench register file, optionally filled with junk so the clear is observable.
    always @(posedge clk) begin
        if (scramble) begin
            for (int i = 0; i < 32; i++) mem[i] <= $urandom | 32'h1;
        end else if (bus.reg_we) begin
            mem[bus.reg_waddr] <= bus.reg_wdata;
        end
    end

    function automatic logic [40:0] pack(input logic we, input logic [4:0] a,
                                         input logic [31:0] d, input logic ack,
                                         input logic stall, input logic busy);
        return {we, a, d, ack, stall, busy};
    endfunction

    function automatic logic [40:0] obs();
        return {bus.reg_we, bus.reg_waddr, bus.reg_wdata,
                bus.aux_ack, bus.stall_req, bus.init_busy};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wb_we = 1'b0; bus.wb_waddr = '0; bus.wb_wdata = '0;
        bus.aux_req = 1'b0; bus.aux_waddr = '0; bus.aux_wdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        scramble = 1'b1;
        bus.wb_we = 1'b1; bus.wb_waddr = 5'd4; bus.wb_wdata = $urandom;
        bus.aux_req = 1'b1; bus.aux_waddr = 5'd6; bus.aux_wdata = $urandom;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            got = obs(); exp_v = pack(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1);
            n_cmp++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL reset c=%0d: actual %h required %h", c, got, exp_v);
            end
            tick();
            scramble = 1'b0;
        end
        bus.aux_req = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_clear(input string tag);
        bus.wb_we = 1'b1; bus.wb_waddr = 5'd3; bus.aux_req = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            bus.wb_wdata = $urandom;
            @(negedge clk);
            got = obs(); exp_v = pack(1'b1, 5'(k), 32'd0, 1'b0, 1'b1, 1'b1);
            n_cmp++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL %s k=%0d: actual %h required %h", tag, k, got, exp_v);
            end
            tick();
        end
        idle_inputs();
        @(negedge clk);
        got = obs(); exp_v = pack(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL %s_done: actual %h required %h", tag, got, exp_v);
        end
        for (int i = 1; i < 32; i++) begin
            n_cmp++;
            if (mem[i] !== 32'd0) begin
                n_err++;
                $display("FAIL %s_readback r%0d: actual %h required 00000000", tag, i, mem[i]);
            end
        end
        tick();
    endtask

    task automatic test_writeback();
        bus.wb_we = 1'b1; bus.wb_waddr = 5'd5; bus.wb_wdata = 32'hDEADBEEF;
        @(negedge clk);
        got = obs(); exp_v = pack(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL writeback: actual %h required %h", got, exp_v);
        end
        tick();
        idle_inputs();
        n_cmp++;
        if (mem[5] !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL writeback_r5: actual %h required deadbeef", mem[5]);
        end
    endtask

    task automatic test_arbitration();
        logic [31:0] d3;
        d3 = $urandom;
        bus.wb_we = 1'b1; bus.wb_waddr = 5'd3; bus.wb_wdata = d3;
        bus.aux_req = 1'b1; bus.aux_waddr = 5'd7; bus.aux_wdata = 32'h12345678;
        @(negedge clk);
        got = obs(); exp_v = pack(1'b1, 5'd3, d3, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL arb_wb_wins: actual %h required %h", got, exp_v);
        end
        tick();
        bus.wb_we = 1'b0;
        @(negedge clk);
        got = obs(); exp_v = pack(1'b1, 5'd7, 32'h12345678, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL arb_aux_grant: actual %h required %h", got, exp_v);
        end
        tick();
        bus.aux_req = 1'b0;
        @(negedge clk);
        got = obs(); exp_v = pack(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL arb_ack_once: actual %h required %h", got, exp_v);
        end
        n_cmp++;
        if (mem[7] !== 32'h12345678 || mem[3] !== d3) begin
            n_err++;
            $display("FAIL arb_regs: actual r7=%h r3=%h required r7=12345678 r3=%h", mem[7], mem[3], d3);
        end
        tick();
    endtask

    task automatic test_starvation(input string tag);
        logic [31:0] ad;
        logic [31:0] wd;
        ad = $urandom;
        wd = '0;
        bus.wb_we = 1'b1; bus.wb_waddr = 5'd9;
        bus.aux_req = 1'b1; bus.aux_waddr = 5'd11; bus.aux_wdata = ad;
        for (int c = 1; c <= LIMIT + 1; c++) begin
            wd = $urandom;
            bus.wb_wdata = wd;
            @(negedge clk);
            got = obs(); exp_v = pack(1'b1, 5'd9, wd, 1'b0, (c > LIMIT), 1'b0);
            n_cmp++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL %s c=%0d: actual %h required %h", tag, c, got, exp_v);
            end
            tick();
        end
        bus.wb_we = 1'b0;
        @(negedge clk);
        got = obs(); exp_v = pack(1'b1, 5'd11, ad, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL %s_grant: actual %h required %h", tag, got, exp_v);
        end
        tick();
        bus.aux_req = 1'b0;
        @(negedge clk);
        got = obs(); exp_v = pack(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL %s_release: actual %h required %h", tag, got, exp_v);
        end
        n_cmp++;
        if (mem[11] !== ad || mem[9] !== wd) begin
            n_err++;
            $display("FAIL %s_regs: actual r11=%h r9=%h required r11=%h r9=%h", tag, mem[11], mem[9], ad, wd);
        end
        tick();
    endtask

    task automatic test_reg0();
        logic [31:0] ad;
        ad = $urandom | 32'h1;
        bus.wb_we = 1'b1; bus.wb_waddr = 5'd0; bus.wb_wdata = $urandom;
        bus.aux_req = 1'b1; bus.aux_waddr = 5'd0; bus.aux_wdata = ad;
        @(negedge clk);
        got = obs(); exp_v = pack(1'b0, 5'd0, ad, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL reg0: actual %h required %h", got, exp_v);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        n_cmp++;
        if (bus.aux_ack !== 1'b0) begin
            n_err++;
            $display("FAIL reg0_ack_once: actual %b required 0", bus.aux_ack);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        // Build up a stall in RUN first so the reset has state to wipe.
        bus.wb_we = 1'b1; bus.wb_waddr = 5'd9; bus.wb_wdata = $urandom;
        bus.aux_req = 1'b1; bus.aux_waddr = 5'd12; bus.aux_wdata = $urandom;
        for (int c = 0; c < LIMIT + 1; c++) tick();
        @(negedge clk);
        n_cmp++;
        if (bus.stall_req !== 1'b1) begin
            n_err++;
            $display("FAIL mid_prestall: actual %b required 1", bus.stall_req);
        end
        tick();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.reg_waddr !== 5'(k) || bus.reg_we !== 1'b1) begin
                n_err++;
                $display("FAIL mid_partial k=%0d: actual a=%0d we=%b required a=%0d we=1", k, bus.reg_waddr, bus.reg_we, k);
            end
            tick();
        end
        rst = 1'b1;
        scramble = 1'b1;
        @(negedge clk);
        got = obs(); exp_v = pack(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL mid_rst: actual %h required %h", got, exp_v);
        end
        tick();
        scramble = 1'b0;
        rst = 1'b0;
        test_clear("mid_clear");
        test_starvation("mid_starve");
    endtask

    task automatic test_random();
        bit          pend;
        int          waits;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        wwe;
        logic        e_we, e_ack, e_stall;
        logic [4:0]  e_a;
        logic [31:0] e_d;
        logic [31:0] model [32];
        pend = 1'b0; waits = 0; aa = '0; ad = '0;
        for (int i = 0; i < 32; i++) model[i] = mem[i];
        for (int c = 0; c < 500; c++) begin
            if (!pend && $urandom_range(2) == 0) begin
                pend = 1'b1;
                aa = ($urandom_range(5) == 0) ? 5'd0 : 5'($urandom_range(31));
                ad = $urandom;
            end
            e_stall = (waits >= LIMIT);
            wwe = e_stall ? 1'b0 : ($urandom_range(3) != 0);
            wa = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
            wd = $urandom;
            bus.wb_we = wwe; bus.wb_waddr = wa; bus.wb_wdata = wd;
            bus.aux_req = pend; bus.aux_waddr = aa; bus.aux_wdata = ad;
            if (wwe && wa != 5'd0) begin
                e_we = 1'b1; e_a = wa; e_d = wd; e_ack = 1'b0;
            end else if (pend) begin
                e_we = (aa != 5'd0); e_a = aa; e_d = ad; e_ack = 1'b1;
            end else begin
                e_we = 1'b0; e_a = '0; e_d = '0; e_ack = 1'b0;
            end
            @(negedge clk);
            got = obs(); exp_v = pack(e_we, e_a, e_d, e_ack, e_stall, 1'b0);
            n_cmp++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL random c=%0d: actual %h required %h", c, got, exp_v);
            end
            if (e_we) model[e_a] = e_d;
            if (e_ack) begin
                pend = 1'b0;
                waits = 0;
            end else if (pend) begin
                waits++;
            end
            tick();
        end
        idle_inputs();
        for (int i = 1; i < 32; i++) begin
            n_cmp++;
            if (mem[i] !== model[i]) begin
                n_err++;
                $display("FAIL random_regs r%0d: actual %h required %h", i, mem[i], model[i]);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        scramble = 1'b0;
        idle_inputs();
        test_reset();
        test_clear("clear");
        test_writeback();
        test_arbitration();
        test_starvation("starve");
        test_reg0();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
